// File: rtl/cache_miss_ctrl_if.sv
// Signal bundle between the miss controller, core load/store path, cache and main memory.
// master = controller view, slave = environment (core/cache/memory) view.
interface cache_miss_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic              hit;
  logic              dirty;
  logic [ADDR_W-1:0] victim_addr;
  logic              stall;
  logic              mm_rd;
  logic              mm_wr;
  logic [ADDR_W-1:0] mm_addr;
  logic [DATA_W-1:0] mm_rdata;
  logic              mm_ack;
  logic              cache_fill;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic [7:0]        miss_cnt;
  logic [7:0]        wb_cnt;
  logic              err;

  modport master (
    input  cpu_rd, cpu_wr, cpu_addr, hit, dirty, victim_addr, mm_rdata, mm_ack,
    output stall, mm_rd, mm_wr, mm_addr, cache_fill, fill_addr, fill_data,
           miss_cnt, wb_cnt, err
  );

  modport slave (
    output cpu_rd, cpu_wr, cpu_addr, hit, dirty, victim_addr, mm_rdata, mm_ack,
    input  stall, mm_rd, mm_wr, mm_addr, cache_fill, fill_addr, fill_data,
           miss_cnt, wb_cnt, err
  );
endinterface

// File: rtl/cache_miss_ctrl.sv
// Cache miss sequencer: stalls the core, writes back a dirty victim, fetches the
// missing byte over a handshaked main-memory port and installs it in the cache.
module cache_miss_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst_n,
  cache_miss_ctrl_if.master bus
);

  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_UPDATE
  } state_t;

  state_t            r_state;
  logic [TO_W-1:0]   r_tcnt;
  logic              r_mm_rd;
  logic              r_mm_wr;
  logic [ADDR_W-1:0] r_mm_addr;
  logic              r_fill;
  logic [ADDR_W-1:0] r_fill_addr;
  logic [DATA_W-1:0] r_fill_data;
  logic [7:0]        r_miss_cnt;
  logic [7:0]        r_wb_cnt;
  logic              r_err;

  logic w_access;
  logic w_miss;
  logic w_timeout;

  assign w_access  = bus.cpu_rd | bus.cpu_wr;
  assign w_miss    = w_access & ~bus.hit;
  assign w_timeout = (r_tcnt == TO_W'(TIMEOUT - 1));

  // Stall is combinational only in IDLE; gated by rst_n so reset forces it low.
  assign bus.stall      = (r_state != S_IDLE) | (w_miss & rst_n);
  assign bus.mm_rd      = r_mm_rd;
  assign bus.mm_wr      = r_mm_wr;
  assign bus.mm_addr    = r_mm_addr;
  assign bus.cache_fill = r_fill;
  assign bus.fill_addr  = r_fill_addr;
  assign bus.fill_data  = r_fill_data;
  assign bus.miss_cnt   = r_miss_cnt;
  assign bus.wb_cnt     = r_wb_cnt;
  assign bus.err        = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tcnt      <= '0;
      r_mm_rd     <= 1'b0;
      r_mm_wr     <= 1'b0;
      r_mm_addr   <= '0;
      r_fill      <= 1'b0;
      r_fill_addr <= '0;
      r_fill_data <= '0;
      r_miss_cnt  <= '0;
      r_wb_cnt    <= '0;
      r_err       <= 1'b0;
    end else begin
      r_fill <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tcnt <= '0;
          if (w_miss) begin
            r_fill_addr <= bus.cpu_addr;
            if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 8'd1;
            if (bus.dirty) begin
              r_state   <= S_WB;
              r_mm_wr   <= 1'b1;
              r_mm_addr <= bus.victim_addr;
            end else begin
              r_state   <= S_FILL;
              r_mm_rd   <= 1'b1;
              r_mm_addr <= bus.cpu_addr;
            end
          end
        end
        S_WB: begin
          if (bus.mm_ack) begin
            if (r_wb_cnt != '1) r_wb_cnt <= r_wb_cnt + 8'd1;
            r_mm_wr   <= 1'b0;
            r_mm_rd   <= 1'b1;
            r_mm_addr <= r_fill_addr;
            r_tcnt    <= '0;
            r_state   <= S_FILL;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_mm_wr <= 1'b0;
            r_tcnt  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tcnt <= r_tcnt + TO_W'(1);
          end
        end
        S_FILL: begin
          if (bus.mm_ack) begin
            r_fill_data <= bus.mm_rdata;
            r_mm_rd     <= 1'b0;
            r_fill      <= 1'b1;
            r_tcnt      <= '0;
            r_state     <= S_UPDATE;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_mm_rd <= 1'b0;
            r_tcnt  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tcnt <= r_tcnt + TO_W'(1);
          end
        end
        S_UPDATE: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule
